// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: small writable program memory, PC and a
// registered valid/ready output slot. JUMP and HALT are resolved here and never issued.
module instr_fetch #(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [1:0]         if_opcode,
    output logic [1:0]         if_funct,
    output logic [PC_W-1:0]    if_pc,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   issue_cnt
);

    localparam int unsigned DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e              r_state, w_state_d;
    logic [PC_W-1:0]     r_pc, w_pc_d;
    logic                r_valid, w_valid_d;
    logic [INSTR_W-1:0]  r_instr, w_instr_d;
    logic [PC_W-1:0]     r_if_pc, w_if_pc_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                r_running, r_halted;
    logic [INSTR_W-1:0]  r_mem [DEPTH];

    logic [INSTR_W-1:0]  w_word;
    logic [1:0]          w_op, w_fn;
    logic                w_xfer, w_free, w_flush;

    assign w_word  = r_mem[r_pc];
    assign w_op    = w_word[INSTR_W-1 -: 2];
    assign w_fn    = w_word[INSTR_W-3 -: 2];
    assign w_xfer  = r_valid && if_ready;
    assign w_free  = !r_valid || if_ready;
    // A redirect in RUN discards the slot, so a same-cycle accept does not count.
    assign w_flush = (r_state == StRun) && redirect_valid;

    // Program memory write port; locked out while running.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state != StRun)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Next-state, fetch/issue and counter logic.
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_valid_d = r_valid;
        w_instr_d = r_instr;
        w_if_pc_d = r_if_pc;
        w_cnt_d   = r_cnt;

        if (w_xfer) begin
            w_valid_d = 1'b0;
            if (!w_flush && (r_cnt != {CNT_W{1'b1}})) begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end

        unique case (r_state)
            StIdle, StHalt: begin
                if (start) begin
                    w_pc_d    = start_pc;
                    w_valid_d = 1'b0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (redirect_valid) begin
                    w_pc_d    = redirect_pc;
                    w_valid_d = 1'b0;
                end else if (w_free) begin
                    if (w_op == 2'b11) begin
                        w_valid_d = 1'b0;
                        w_state_d = StHalt;
                    end else if (w_op == 2'b10 && w_fn == 2'b11) begin
                        w_pc_d    = w_word[PC_W-1:0];
                        w_valid_d = 1'b0;
                    end else begin
                        w_instr_d = w_word;
                        w_if_pc_d = r_pc;
                        w_valid_d = 1'b1;
                        w_pc_d    = r_pc + PC_W'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_if_pc   <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_valid   <= w_valid_d;
            r_instr   <= w_instr_d;
            r_if_pc   <= w_if_pc_d;
            r_cnt     <= w_cnt_d;
            r_running <= (w_state_d == StRun);
            r_halted  <= (w_state_d == StHalt);
        end
    end

    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_opcode = r_instr[INSTR_W-1 -: 2];
    assign if_funct  = r_instr[INSTR_W-3 -: 2];
    assign if_pc     = r_if_pc;
    assign running   = r_running;
    assign halted    = r_halted;
    assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       start;
    logic [3:0] start_pc;
    logic       redirect_valid;
    logic [3:0] redirect_pc;
    logic       if_valid;
    logic       if_ready;
    logic [7:0] if_instr;
    logic [1:0] if_opcode;
    logic [1:0] if_funct;
    logic [3:0] if_pc;
    logic       running;
    logic       halted;
    logic [7:0] issue_cnt;

    int n_total = 0;
    int n_bad   = 0;

    instr_fetch #(.PC_W(4), .INSTR_W(8), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_funct       (if_funct),
        .if_pc          (if_pc),
        .running        (running),
        .halted         (halted),
        .issue_cnt      (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic kick(input logic [3:0] pc);
        start    = 1'b1;
        start_pc = pc;
        tick();
        start    = 1'b0;
    endtask

    // Expect a valid slot holding instr at address pc.
    task automatic expect_slot(input string tag, input logic [7:0] instr, input logic [3:0] pc);
        check({tag, ".valid"}, 32'(if_valid), 32'd1);
        check({tag, ".instr"}, 32'(if_instr), 32'(instr));
        check({tag, ".pc"}, 32'(if_pc), 32'(pc));
    endtask

    initial begin
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; start_pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
        if_ready = 1'b1;
        tick(); tick();
        check("rst.valid", 32'(if_valid), 32'd0);
        check("rst.instr", 32'(if_instr), 32'd0);
        check("rst.pc", 32'(if_pc), 32'd0);
        check("rst.cnt", 32'(issue_cnt), 32'd0);
        check("rst.running", 32'(running), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        // Straight-line program ending in HALT.
        load(4'd0, 8'h05); load(4'd1, 8'h90); load(4'd2, 8'h60); load(4'd3, 8'hC0);
        kick(4'd0);
        check("t1.running", 32'(running), 32'd1);
        check("t1.bubble", 32'(if_valid), 32'd0);
        tick(); expect_slot("t1.i0", 8'h05, 4'd0);
        tick(); expect_slot("t1.i1", 8'h90, 4'd1);
        check("t1.opcode", 32'(if_opcode), 32'd2);
        check("t1.funct", 32'(if_funct), 32'd1);
        tick(); expect_slot("t1.i2", 8'h60, 4'd2);
        tick();
        check("t1.hvalid", 32'(if_valid), 32'd0);
        check("t1.halted", 32'(halted), 32'd1);
        check("t1.running", 32'(running), 32'd0);
        check("t1.cnt", 32'(issue_cnt), 32'd3);

        // JUMP produces a bubble and is never issued.
        do_reset();
        load(4'd0, 8'h06); load(4'd1, 8'hB4); load(4'd4, 8'h10); load(4'd5, 8'hC0);
        kick(4'd0);
        tick(); expect_slot("t2.i0", 8'h06, 4'd0);
        tick(); check("t2.bubble", 32'(if_valid), 32'd0);
        tick(); expect_slot("t2.i1", 8'h10, 4'd4);
        tick();
        check("t2.halted", 32'(halted), 32'd1);
        check("t2.cnt", 32'(issue_cnt), 32'd2);

        // Backpressure holds the slot.
        do_reset();
        if_ready = 1'b0;
        kick(4'd0);
        tick(); expect_slot("t3.first", 8'h06, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_slot("t3.hold", 8'h06, 4'd0);
            check("t3.cnt", 32'(issue_cnt), 32'd0);
        end
        if_ready = 1'b1;
        tick();
        check("t3.bubble", 32'(if_valid), 32'd0);
        check("t3.cnt1", 32'(issue_cnt), 32'd1);
        tick(); expect_slot("t3.i1", 8'h10, 4'd4);

        // Redirect flushes the slot even with ready high.
        do_reset();
        load(4'd0, 8'h01); load(4'd1, 8'h02); load(4'd2, 8'h03); load(4'd3, 8'hC0);
        load(4'd9, 8'h0A); load(4'd10, 8'hC0);
        kick(4'd0);
        tick(); expect_slot("t4.i0", 8'h01, 4'd0);
        tick(); expect_slot("t4.i1", 8'h02, 4'd1);
        tick(); expect_slot("t4.i2", 8'h03, 4'd2);
        redirect_valid = 1'b1; redirect_pc = 4'd9;
        tick();
        redirect_valid = 1'b0;
        check("t4.flush", 32'(if_valid), 32'd0);
        check("t4.cnt", 32'(issue_cnt), 32'd2);
        tick(); expect_slot("t4.tgt", 8'h0A, 4'd9);
        tick();
        check("t4.halted", 32'(halted), 32'd1);
        check("t4.cnt2", 32'(issue_cnt), 32'd3);

        // Program writes ignored in RUN, honoured in HALT.
        do_reset();
        if_ready = 1'b0;
        kick(4'd0);
        tick(); expect_slot("t5.i0", 8'h01, 4'd0);
        load(4'd3, 8'h77);
        if_ready = 1'b1;
        tick(); expect_slot("t5.i1", 8'h02, 4'd1);
        tick(); expect_slot("t5.i2", 8'h03, 4'd2);
        tick();
        check("t5.novalid", 32'(if_valid), 32'd0);
        check("t5.halted", 32'(halted), 32'd1);
        check("t5.cnt", 32'(issue_cnt), 32'd3);
        load(4'd3, 8'h5A); load(4'd4, 8'hC0);
        kick(4'd3);
        tick(); expect_slot("t5.new", 8'h5A, 4'd3);
        tick(); check("t5.halted2", 32'(halted), 32'd1);

        // Reset mid-stream with a pending slot.
        do_reset();
        if_ready = 1'b0;
        kick(4'd0);
        tick(); expect_slot("t6.i0", 8'h01, 4'd0);
        rst_n = 1'b0;
        tick();
        check("t6.valid", 32'(if_valid), 32'd0);
        check("t6.instr", 32'(if_instr), 32'd0);
        check("t6.pc", 32'(if_pc), 32'd0);
        check("t6.cnt", 32'(issue_cnt), 32'd0);
        check("t6.running", 32'(running), 32'd0);
        check("t6.halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        if_ready = 1'b1;
        kick(4'd2);
        tick(); expect_slot("t6.restart", 8'h03, 4'd2);

        // Counter saturation: loop 01,02,JUMP 0 issues 2 per 3 cycles.
        do_reset();
        load(4'd0, 8'h01); load(4'd1, 8'h02); load(4'd2, 8'hB0);
        kick(4'd0);
        for (int i = 0; i < 420; i++) tick();
        check("t7.sat", 32'(issue_cnt), 32'd255);
        check("t7.running", 32'(running), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
